// File: rtl/dual_port_sync_ram_if.sv
// Bus bundle for dual_port_sync_ram.
// Port A is read/write with byte enables; port B is read-only.
interface dual_port_sync_ram_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                    a_req;
    logic                    a_we;
    logic [DATA_WIDTH/8-1:0] a_be;
    logic [ADDR_WIDTH-1:0]   a_addr;
    logic [DATA_WIDTH-1:0]   a_wdata;
    logic [DATA_WIDTH-1:0]   a_rdata;
    logic                    a_valid;
    logic                    a_err;
    logic                    b_req;
    logic [ADDR_WIDTH-1:0]   b_addr;
    logic [DATA_WIDTH-1:0]   b_rdata;
    logic                    b_valid;
    logic                    b_err;
    logic                    b_coll;

    modport master (
        output a_req, a_we, a_be, a_addr, a_wdata,
        input  a_rdata, a_valid, a_err,
        output b_req, b_addr,
        input  b_rdata, b_valid, b_err, b_coll
    );

    modport slave (
        input  a_req, a_we, a_be, a_addr, a_wdata,
        output a_rdata, a_valid, a_err,
        input  b_req, b_addr,
        output b_rdata, b_valid, b_err, b_coll
    );
endinterface

// File: rtl/dual_port_sync_ram.sv
// Dual-port synchronous RAM: A read/write, B read-only,
// fully pipelined with 1 or 2 cycles of read latency.
`ifndef DECODER_MEM_ADDR_WIDTH
`define DECODER_MEM_ADDR_WIDTH 8
`endif
`ifndef DECODER_MEM_DATA_WIDTH
`define DECODER_MEM_DATA_WIDTH 32
`endif
`ifndef DECODER_MEM_DATA_DEPTH
`define DECODER_MEM_DATA_DEPTH 256
`endif

module dual_port_sync_ram #(
    parameter int INIT_FROM_FILE = 1,
    parameter     FILE_DATA      = "rom_image.mem",
    parameter int ADDR_WIDTH     = `DECODER_MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH     = `DECODER_MEM_DATA_WIDTH,
    parameter int MEM_DEPTH      = `DECODER_MEM_DATA_DEPTH,
    parameter int RD_LATENCY     = 1
) (
    input logic                 clk,
    input logic                 reset,
    dual_port_sync_ram_if.slave bus
);

    localparam int NB = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  a_inr;
    logic                  b_inr;
    logic                  a_wr;

    logic                  a1_valid;
    logic                  a1_err;
    logic [DATA_WIDTH-1:0] a1_rdata;
    logic                  b1_valid;
    logic                  b1_err;
    logic                  b1_coll;
    logic [DATA_WIDTH-1:0] b1_rdata;

    assign a_inr = {1'b0, bus.a_addr} < DEPTH;
    assign b_inr = {1'b0, bus.b_addr} < DEPTH;
    assign a_wr  = bus.a_req && bus.a_we && a_inr;

    always_ff @(posedge clk) begin
        if (reset && a_wr) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.a_be[i])
                    mem[bus.a_addr][8*i +: 8] <= bus.a_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a1_valid <= 1'b0;
            a1_err   <= 1'b0;
            a1_rdata <= '0;
            b1_valid <= 1'b0;
            b1_err   <= 1'b0;
            b1_coll  <= 1'b0;
            b1_rdata <= '0;
        end else begin
            a1_valid <= bus.a_req;
            a1_err   <= bus.a_req && !a_inr;
            if (bus.a_req)
                a1_rdata <= (!bus.a_we && a_inr) ? mem[bus.a_addr] : '0;
            b1_valid <= bus.b_req;
            b1_err   <= bus.b_req && !b_inr;
            b1_coll  <= bus.b_req && b_inr && a_wr && (bus.a_addr == bus.b_addr);
            if (bus.b_req)
                b1_rdata <= b_inr ? mem[bus.b_addr] : '0;
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic                  a2_valid;
            logic                  a2_err;
            logic [DATA_WIDTH-1:0] a2_rdata;
            logic                  b2_valid;
            logic                  b2_err;
            logic                  b2_coll;
            logic [DATA_WIDTH-1:0] b2_rdata;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    a2_valid <= 1'b0;
                    a2_err   <= 1'b0;
                    a2_rdata <= '0;
                    b2_valid <= 1'b0;
                    b2_err   <= 1'b0;
                    b2_coll  <= 1'b0;
                    b2_rdata <= '0;
                end else begin
                    a2_valid <= a1_valid;
                    a2_err   <= a1_err;
                    if (a1_valid)
                        a2_rdata <= a1_rdata;
                    b2_valid <= b1_valid;
                    b2_err   <= b1_err;
                    b2_coll  <= b1_coll;
                    if (b1_valid)
                        b2_rdata <= b1_rdata;
                end
            end

            assign bus.a_valid = a2_valid;
            assign bus.a_err   = a2_err;
            assign bus.a_rdata = a2_rdata;
            assign bus.b_valid = b2_valid;
            assign bus.b_err   = b2_err;
            assign bus.b_coll  = b2_coll;
            assign bus.b_rdata = b2_rdata;
        end else begin : g_lat1
            assign bus.a_valid = a1_valid;
            assign bus.a_err   = a1_err;
            assign bus.a_rdata = a1_rdata;
            assign bus.b_valid = b1_valid;
            assign bus.b_err   = b1_err;
            assign bus.b_coll  = b1_coll;
            assign bus.b_rdata = b1_rdata;
        end
    endgenerate

endmodule

// File: tb/tb_dual_port_sync_ram.sv
// Directed bench for dual_port_sync_ram at read latency 1 (u1) and 2 (u2).
module tb_dual_port_sync_ram;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int DEPTH = 12;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    dual_port_sync_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) i1 ();
    dual_port_sync_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) i2 ();

    dual_port_sync_ram #(
        .INIT_FROM_FILE(0), .FILE_DATA("rom_image.mem"),
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .MEM_DEPTH(DEPTH), .RD_LATENCY(1)
    ) u1 (.clk(clk), .reset(reset), .bus(i1));

    dual_port_sync_ram #(
        .INIT_FROM_FILE(0), .FILE_DATA("rom_image.mem"),
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .MEM_DEPTH(DEPTH), .RD_LATENCY(2)
    ) u2 (.clk(clk), .reset(reset), .bus(i2));

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i1.a_req = 0; i1.a_we = 0; i1.a_be = '0; i1.a_addr = '0;
        i1.a_wdata = '0; i1.b_req = 0; i1.b_addr = '0;
        i2.a_req = 0; i2.a_we = 0; i2.a_be = '0; i2.a_addr = '0;
        i2.a_wdata = '0; i2.b_req = 0; i2.b_addr = '0;
    endtask

    task automatic a1_op(input logic we, input logic [1:0] be,
                         input logic [3:0] addr, input logic [15:0] d);
        i1.a_req = 1; i1.a_we = we; i1.a_be = be;
        i1.a_addr = addr; i1.a_wdata = d;
    endtask

    task automatic a2_op(input logic we, input logic [1:0] be,
                         input logic [3:0] addr, input logic [15:0] d);
        i2.a_req = 1; i2.a_we = we; i2.a_be = be;
        i2.a_addr = addr; i2.a_wdata = d;
    endtask

    initial begin
        idle();
        tick();
        tick();
        check("rst_a_valid", 32'(i1.a_valid), 0);
        check("rst_a_rdata", 32'(i1.a_rdata), 0);
        check("rst_b_valid", 32'(i2.b_valid), 0);
        reset = 1'b1;

        // write 5 BEEF then read it back
        a1_op(1, 2'b11, 4'd5, 16'hBEEF);
        tick();
        check("wr5_valid", 32'(i1.a_valid), 1);
        check("wr5_rdata", 32'(i1.a_rdata), 0);
        a1_op(0, 2'b00, 4'd5, 16'h0);
        tick();
        check("rd5_valid", 32'(i1.a_valid), 1);
        check("rd5_data", 32'(i1.a_rdata), 32'hBEEF);
        check("rd5_err", 32'(i1.a_err), 0);
        idle();
        tick();
        check("bubble_valid", 32'(i1.a_valid), 0);
        check("hold_rdata", 32'(i1.a_rdata), 32'hBEEF);

        // byte-enable merge
        a1_op(1, 2'b11, 4'd3, 16'h1234);
        tick();
        a1_op(1, 2'b10, 4'd3, 16'hABCD);
        tick();
        a1_op(0, 2'b00, 4'd3, 16'h0);
        tick();
        check("rd3_merge", 32'(i1.a_rdata), 32'hAB34);
        a1_op(1, 2'b00, 4'd3, 16'hFFFF);
        tick();
        check("be0_valid", 32'(i1.a_valid), 1);
        a1_op(0, 2'b00, 4'd3, 16'h0);
        tick();
        check("be0_nochg", 32'(i1.a_rdata), 32'hAB34);

        // same-cycle collision
        a1_op(1, 2'b11, 4'd7, 16'h0000);
        tick();
        a1_op(1, 2'b11, 4'd7, 16'h5555);
        i1.b_req = 1; i1.b_addr = 4'd7;
        tick();
        check("coll_valid", 32'(i1.b_valid), 1);
        check("coll_old", 32'(i1.b_rdata), 0);
        check("coll_flag", 32'(i1.b_coll), 1);
        i1.a_req = 0;
        tick();
        check("coll2_data", 32'(i1.b_rdata), 32'h5555);
        check("coll2_flag", 32'(i1.b_coll), 0);

        // out of range
        idle();
        a1_op(0, 2'b00, 4'd12, 16'h0);
        i1.b_req = 1; i1.b_addr = 4'd15;
        tick();
        check("oor_a_valid", 32'(i1.a_valid), 1);
        check("oor_a_err", 32'(i1.a_err), 1);
        check("oor_a_rdata", 32'(i1.a_rdata), 0);
        check("oor_b_err", 32'(i1.b_err), 1);
        check("oor_b_rdata", 32'(i1.b_rdata), 0);
        idle();
        a1_op(1, 2'b11, 4'd13, 16'hDEAD);
        tick();
        check("oor_w_err", 32'(i1.a_err), 1);
        a1_op(0, 2'b00, 4'd5, 16'h0);
        tick();
        check("oor_w_nochg", 32'(i1.a_rdata), 32'hBEEF);
        check("inr_err", 32'(i1.a_err), 0);

        // latency 2: writes then back-to-back B reads
        idle();
        a2_op(1, 2'b11, 4'd0, 16'h1111);
        tick();
        check("l2_w0_nv", 32'(i2.a_valid), 0);
        a2_op(1, 2'b11, 4'd1, 16'h2222);
        tick();
        check("l2_w1_v", 32'(i2.a_valid), 1);
        a2_op(1, 2'b11, 4'd2, 16'h3333);
        tick();
        i2.a_req = 0;
        i2.b_req = 1; i2.b_addr = 4'd0;
        tick();
        check("l2_b_e1", 32'(i2.b_valid), 0);
        i2.b_addr = 4'd1;
        tick();
        check("l2_b0_v", 32'(i2.b_valid), 1);
        check("l2_b0_d", 32'(i2.b_rdata), 32'h1111);
        i2.b_addr = 4'd2;
        tick();
        check("l2_b1_v", 32'(i2.b_valid), 1);
        check("l2_b1_d", 32'(i2.b_rdata), 32'h2222);
        i2.b_req = 0;
        tick();
        check("l2_b2_v", 32'(i2.b_valid), 1);
        check("l2_b2_d", 32'(i2.b_rdata), 32'h3333);
        tick();
        check("l2_b_end", 32'(i2.b_valid), 0);
        check("l2_b_hold", 32'(i2.b_rdata), 32'h3333);

        // reset with two reads in flight
        a2_op(0, 2'b00, 4'd1, 16'h0);
        tick();
        a2_op(0, 2'b00, 4'd2, 16'h0);
        tick();
        check("l2_pre_rst_v", 32'(i2.a_valid), 1);
        check("l2_pre_rst_d", 32'(i2.a_rdata), 32'h2222);
        #1 reset = 1'b0;
        #1;
        check("rst_now_v", 32'(i2.a_valid), 0);
        check("rst_now_d", 32'(i2.a_rdata), 0);
        check("rst_now_b", 32'(i1.b_rdata), 0);
        tick();
        check("rst_hold_v", 32'(i2.a_valid), 0);
        tick();
        idle();
        reset = 1'b1;
        tick();
        check("post_rst_v1", 32'(i2.a_valid), 0);
        tick();
        check("post_rst_v2", 32'(i2.a_valid), 0);
        a2_op(0, 2'b00, 4'd2, 16'h0);
        a1_op(0, 2'b00, 4'd5, 16'h0);
        tick();
        check("first_req_l1", 32'(i1.a_rdata), 32'hBEEF);
        check("first_req_l2n", 32'(i2.a_valid), 0);
        idle();
        tick();
        check("retain_v", 32'(i2.a_valid), 1);
        check("retain_d", 32'(i2.a_rdata), 32'h3333);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
